pwm_cfg_ctrl: RTL
=================

# pwm_cfg_ctrl

Configuration sequencer for the PWM core. Accepts a frequency/duty request over a valid/ready handshake and range-checks it. Computes the period and high-time counts with a shared sequential divider instead of combinational division. Applies the new counts glitch-free at the PWM period boundary. Sits between the user-input/keypad logic and the PWM counter, replacing the raw `sw_ok` load path.

## Interface
Parameters:
- CLK_HZ, 100_000_000 — system clock frequency in Hz
- FRQ_MIN, 1 — lowest accepted frequency, Hz
- FRQ_MAX, 1_000_000 — highest accepted frequency, Hz
- DUTY_MAX, 100 — highest accepted duty, percent

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- cfg_valid  in  1  request valid
- cfg_ready  out  1  block can accept a request
- cfg_frq  in  32  requested frequency, Hz
- cfg_duty  in  20  requested duty, percent
- cfg_err  out  1  one-cycle pulse: request rejected
- period_end  in  1  one-cycle pulse from PWM core on last count of a period
- period_cnt  out  32  clocks per PWM period, to PWM core
- high_cnt  out  32  clocks of high time per period, to PWM core
- upd  out  1  one-cycle pulse in the cycle new counts become visible
- busy  out  1  a request is being processed or armed

## Operation
- Reset values:
  - period_cnt = CLK_HZ/200_000 (500)
  - high_cnt = period_cnt/2 (250)
  - cfg_ready = 1
  - cfg_err, upd and busy = 0
  - FSM in IDLE
- Handshake: transfer occurs when cfg_valid && cfg_ready. cfg_ready = 1 only in IDLE. The request is captured into internal registers on transfer, so cfg_frq and cfg_duty may change afterwards.
- FSM states: IDLE, CHECK, DIV1, MUL, DIV2, ARM.
  - IDLE: on transfer, go to CHECK.
  - CHECK: reject if cfg_frq < FRQ_MIN, cfg_frq > FRQ_MAX, or cfg_duty > DUTY_MAX. On reject, pulse cfg_err and return to IDLE; outputs are unchanged. Otherwise start the divider with CLK_HZ / frq and go to DIV1.
  - DIV1: on divider done, latch the quotient as p_new and go to MUL.
  - MUL: prod = p_new * duty as a 64-bit product. Start the divider with prod / 100 and go to DIV2.
  - DIV2: on done, latch the quotient as h_new and go to ARM.
  - ARM: wait for period_end. In the cycle after period_end is sampled high, period_cnt and high_cnt take p_new and h_new, upd pulses, and the FSM returns to IDLE.
- Arithmetic: unsigned throughout, quotients truncated.
  - duty 0 → high_cnt 0.
  - duty 100 → high_cnt = period_cnt.
  - FRQ_MAX bounds period_cnt ≥ CLK_HZ/FRQ_MAX.
- busy = 1 in every state except IDLE.
- period_end is ignored outside ARM. Nothing is queued; later requests stall on cfg_ready.
- Reset mid-operation: any pending request is discarded and all outputs return to their reset values.

## Timing
- Divider: start sampled at cycle t; quotient and done valid at t+64 (one bit per cycle, 64 iterations).
- Transfer at cycle T:
  - CHECK at T+1.
  - cfg_err (if rejected) at T+2.
  - ARM entered at T+133.
- Apply latency: period_end sampled at cycle P in ARM → outputs and upd change at P+1.
- Back-to-back: cfg_ready rises in the cycle after upd or cfg_err.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package pwm_pkg holds:
  - shared width constants (FRQ_W = 32, DUTY_W = 20, CNT_W = 32)
  - the FSM state enum
  - reset defaults (DEF_FRQ = 200_000, DEF_DUTY = 50)
- Sub-module seq_div:
  - 64-bit unsigned restoring divider with start/done
  - divisor of 0 yields all-ones (unreachable here)
  - one instance, time-shared between DIV1 and DIV2

## Test plan
- Reset → period_cnt=500, high_cnt=250, cfg_ready=1, busy=0.
- Request 100_000 Hz, 25% → after ARM, period_end pulse → next cycle period_cnt=1000, high_cnt=250, upd=1.
- Request 0 Hz → cfg_err at T+2, outputs unchanged. Request 1 kHz, duty 101 → same.
- Duty 0 and duty 100 at 50 kHz → high_cnt=0, then high_cnt=2000=period_cnt.
- cfg_valid held high with a second request during DIV1 → cfg_ready=0 until upd. Second request is accepted the cycle after upd. period_end pulses during DIV1/DIV2 have no effect.
- rstn asserted while in ARM → outputs return to 500/250 and the pending config is never applied.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM configuration path:
//   - bus widths for frequency, duty and the count outputs
//   - sequencer state enum
//   - reset defaults (200 kHz, 50 %) from which the power-on counts derive
//   - one restoring-division step, used by seq_div
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int FRQ_W  = 32;
    localparam int DUTY_W = 20;
    localparam int CNT_W  = 32;
    localparam int DIV_W  = 64;

    localparam int unsigned DEF_FRQ  = 200_000;
    localparam int unsigned DEF_DUTY = 50;
    localparam int unsigned PCT_FULL = 100;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV1,
        MUL,
        DIV2,
        ARM
    } state_e;

    typedef struct packed {
        logic [DIV_W-1:0] rem;
        logic [DIV_W-1:0] quo;
    } div_step_t;

    // One restoring step: shift the next dividend bit (MSB of quo) into the
    // partial remainder, subtract the divisor if it fits and shift the
    // resulting quotient bit into the LSB of quo.  The shifted remainder needs
    // one extra bit for the compare; after a successful subtract the result is
    // below the divisor, so the low DIV_W bits of the difference are exact.
    function automatic div_step_t div_step(
        input logic [DIV_W-1:0] rem,
        input logic [DIV_W-1:0] quo,
        input logic [DIV_W-1:0] dvs
    );
        div_step_t    res;
        logic [DIV_W:0] rem_sh;
        logic         ge;
        rem_sh  = {rem, quo[DIV_W-1]};
        ge      = (rem_sh >= {1'b0, dvs});
        res.rem = ge ? (rem_sh[DIV_W-1:0] - dvs) : rem_sh[DIV_W-1:0];
        res.quo = {quo[DIV_W-2:0], ge};
        return res;
    endfunction

endpackage

// File: rtl/pwm_cfg_ctrl_if.sv
// -----------------------------------------------------------------------------
// pwm_cfg_ctrl_if
// Request channel into the PWM configuration sequencer.
//   cfg_valid  master->slave  request valid
//   cfg_ready  slave->master  sequencer idle and able to take a request
//   cfg_frq    master->slave  requested frequency, Hz
//   cfg_duty   master->slave  requested duty, percent
//   cfg_err    slave->master  one-cycle pulse: request rejected by range check
// -----------------------------------------------------------------------------
interface pwm_cfg_ctrl_if;
    import pwm_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [FRQ_W-1:0]  cfg_frq;
    logic [DUTY_W-1:0] cfg_duty;
    logic              cfg_err;

    modport master (
        output cfg_valid,
        output cfg_frq,
        output cfg_duty,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_frq,
        input  cfg_duty,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/pwm_cfg_ctrl_seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
// 64-bit unsigned restoring divider, one quotient bit per clock.
//   clk       system clock
//   rstn      asynchronous active-low reset
//   start     sample dividend/divisor and begin (first step done on this edge)
//   dividend  64-bit numerator
//   divisor   64-bit denominator; 0 yields an all-ones quotient
//   done      one-cycle pulse, quotient valid; start at cycle t -> done at t+64
//   quotient  low QW bits of the quotient (callers here never exceed 32 bits)
// -----------------------------------------------------------------------------
module seq_div
    import pwm_pkg::*;
#(
    parameter int QW = 32
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [QW-1:0]    quotient
);

    logic [DIV_W-1:0] rem_reg;
    logic [DIV_W-1:0] quo_reg;
    logic [DIV_W-1:0] dvs_reg;
    logic [6:0]       cnt_reg;
    logic             run_reg;
    logic             done_reg;
    div_step_t        step;

    // The start edge already performs the first of the 64 steps on the fresh
    // operands, so 63 further edges finish the job and done lands at t+64.
    always_comb begin
        if (start) begin
            step = div_step({DIV_W{1'b0}}, dividend, divisor);
        end else begin
            step = div_step(rem_reg, quo_reg, dvs_reg);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                rem_reg <= step.rem;
                quo_reg <= step.quo;
                dvs_reg <= divisor;
                cnt_reg <= 7'(DIV_W - 1);
                run_reg <= 1'b1;
            end else if (run_reg) begin
                rem_reg <= step.rem;
                quo_reg <= step.quo;
                cnt_reg <= cnt_reg - 7'd1;
                if (cnt_reg == 7'd1) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done     = done_reg;
    assign quotient = quo_reg[QW-1:0];

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_cfg_ctrl
// Configuration sequencer for the PWM core.  Takes a frequency/duty request,
// range-checks it, derives period and high-time counts with a shared
// sequential divider and hands them to the PWM counter at a period boundary.
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   cfg         request channel (valid/ready/frq/duty/err), slave side
//   period_end  one-cycle pulse from the PWM core on the last count of a period
//   period_cnt  clocks per PWM period
//   high_cnt    clocks of high time per period
//   upd         one-cycle pulse in the cycle new counts become visible
//   busy        a request is being processed or is armed
// -----------------------------------------------------------------------------
module pwm_cfg_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned FRQ_MIN  = 1,
    parameter int unsigned FRQ_MAX  = 1_000_000,
    parameter int unsigned DUTY_MAX = 100
)
(
    input  logic              clk,
    input  logic              rstn,
    pwm_cfg_ctrl_if.slave     cfg,
    input  logic              period_end,
    output logic [CNT_W-1:0]  period_cnt,
    output logic [CNT_W-1:0]  high_cnt,
    output logic              upd,
    output logic              busy
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(CLK_HZ / DEF_FRQ);
    localparam logic [CNT_W-1:0] RST_HIGH   =
        CNT_W'(((CLK_HZ / DEF_FRQ) * DEF_DUTY) / PCT_FULL);

    state_e            state_reg;
    logic              ready_reg;
    logic              err_reg;
    logic              upd_reg;
    logic              busy_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [CNT_W-1:0]  high_reg;

    logic [FRQ_W-1:0]  frq_reg;
    logic [DUTY_W-1:0] duty_reg;
    logic [CNT_W-1:0]  p_new_reg;
    logic [CNT_W-1:0]  h_new_reg;

    logic              div_start_reg;
    logic [DIV_W-1:0]  div_dvd_reg;
    logic [DIV_W-1:0]  div_dvs_reg;
    logic              div_done;
    logic [CNT_W-1:0]  div_quo;

    logic              req_bad;
    logic [DIV_W-1:0]  prod;

    // Range check works on the captured request, never on the live bus.
    assign req_bad = (frq_reg < FRQ_MIN) ||
                     (frq_reg > FRQ_MAX) ||
                     (32'(duty_reg) > DUTY_MAX);

    // Full-width product so the later /100 sees no truncation.
    assign prod = DIV_W'(p_new_reg) * DIV_W'(duty_reg);

    // Divider operands and start are registered; this adds one cycle per
    // division and keeps the range-check/multiply paths off the divider.
    seq_div #(
        .QW (CNT_W)
    ) u_div (
        .clk      (clk),
        .rstn     (rstn),
        .start    (div_start_reg),
        .dividend (div_dvd_reg),
        .divisor  (div_dvs_reg),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            err_reg       <= 1'b0;
            upd_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            period_reg    <= RST_PERIOD;
            high_reg      <= RST_HIGH;
            frq_reg       <= '0;
            duty_reg      <= '0;
            p_new_reg     <= '0;
            h_new_reg     <= '0;
            div_start_reg <= 1'b0;
            div_dvd_reg   <= '0;
            div_dvs_reg   <= '0;
        end else begin
            div_start_reg <= 1'b0;
            err_reg       <= 1'b0;
            upd_reg       <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Returning to IDLE drops ready for one cycle, so ready
                    // reappears the cycle after upd / cfg_err.
                    ready_reg <= 1'b1;
                    if (cfg.cfg_valid && ready_reg) begin
                        frq_reg   <= cfg.cfg_frq;
                        duty_reg  <= cfg.cfg_duty;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= CHECK;
                    end
                end

                CHECK: begin
                    if (req_bad) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        div_dvd_reg   <= DIV_W'(CLK_HZ);
                        div_dvs_reg   <= DIV_W'(frq_reg);
                        div_start_reg <= 1'b1;
                        state_reg     <= DIV1;
                    end
                end

                DIV1: begin
                    if (div_done) begin
                        p_new_reg <= div_quo;
                        state_reg <= MUL;
                    end
                end

                MUL: begin
                    div_dvd_reg   <= prod;
                    div_dvs_reg   <= DIV_W'(PCT_FULL);
                    div_start_reg <= 1'b1;
                    state_reg     <= DIV2;
                end

                DIV2: begin
                    if (div_done) begin
                        h_new_reg <= div_quo;
                        state_reg <= ARM;
                    end
                end

                ARM: begin
                    // Swap both counts together on the boundary so the PWM
                    // core never sees a mixed old/new pair.
                    if (period_end) begin
                        period_reg <= p_new_reg;
                        high_reg   <= h_new_reg;
                        upd_reg    <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = ready_reg;
    assign cfg.cfg_err   = err_reg;
    assign period_cnt    = period_reg;
    assign high_cnt      = high_reg;
    assign upd           = upd_reg;
    assign busy          = busy_reg;

endmodule
